// File: rtl/rgs_rng_arbiter.sv
// -----------------------------------------------------------------------------
// rgs_rng_arbiter
//
// Shares one randomizer core among NREQ requesters. Each transaction picks a
// winner by round-robin, pulses rng_next once to advance the core, waits for
// rng_valid (or gives up after TIMEOUT fetch cycles), then returns the word to
// the winner with a one-cycle gnt/dout_valid pulse.
//
// Optional feature macro: RGS_ARB_STATS_EN
//   defined   -> gnt_count is a saturating count of delivered grants
//   undefined -> gnt_count is tied to 0
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   req          level requests, one bit per requester
//   gnt          one-hot grant pulse, coincident with dout_valid
//   dout         delivered random word (0 on a timeout delivery)
//   dout_valid   delivery strobe
//   timeout_err  delivery came from a fetch timeout
//   busy         transaction in progress (any state except IDLE)
//   rng_next     advance strobe to the core, once per transaction
//   rng_data     core output word
//   rng_valid    rng_data valid this cycle
//   gnt_count    grant statistics
// -----------------------------------------------------------------------------
module rgs_rng_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [DW-1:0]   dout,
    output logic            dout_valid,
    output logic            timeout_err,
    output logic            busy,
    output logic            rng_next,
    input  logic [DW-1:0]   rng_data,
    input  logic            rng_valid,
    output logic [15:0]     gnt_count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [IW-1:0]   last_reg, last_next;
    logic [TW-1:0]   cnt_reg, cnt_next;
    logic [DW-1:0]   dout_reg, dout_next;
    logic            err_reg, err_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic            dv_reg, dv_next;
    logic            busy_reg, busy_next;
    logic            strobe_reg, strobe_next;

    logic [NREQ-1:0] gnt_dec;
    logic [IW:0]     pick;

    // Round-robin search starting at last+1. Iterating from the farthest
    // offset down to the nearest lets the nearest active requester win.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   last);
        logic [IW:0] res;
        int          c;
        res = '0;
        for (int i = NREQ; i >= 1; i--) begin
            c = (int'(last) + i) % NREQ;
            if (r[c]) begin
                res = {1'b1, IW'(c)};
            end
        end
        return res;
    endfunction

    assign pick = rr_pick(req, last_reg);

    // One-hot decode of the registered winner index.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_dec
            assign gnt_dec[gi] = (idx_reg == IW'(gi));
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        last_next   = last_reg;
        cnt_next    = cnt_reg;
        dout_next   = '0;
        err_next    = 1'b0;
        gnt_next    = '0;
        dv_next     = 1'b0;
        strobe_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick[IW]) begin
                    idx_next    = pick[IW-1:0];
                    cnt_next    = '0;
                    strobe_next = 1'b1;
                    state_next  = FETCH;
                end
            end
            FETCH: begin
                // Data takes priority over a simultaneous counter expiry.
                if (rng_valid) begin
                    dout_next  = rng_data;
                    gnt_next   = gnt_dec;
                    dv_next    = 1'b1;
                    state_next = DELIVER;
                end else if (cnt_reg == TW'(TIMEOUT)) begin
                    err_next   = 1'b1;
                    gnt_next   = gnt_dec;
                    dv_next    = 1'b1;
                    state_next = DELIVER;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DELIVER: begin
                last_next  = idx_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            last_reg   <= IW'(NREQ - 1);
            cnt_reg    <= '0;
            dout_reg   <= '0;
            err_reg    <= 1'b0;
            gnt_reg    <= '0;
            dv_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            strobe_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            last_reg   <= last_next;
            cnt_reg    <= cnt_next;
            dout_reg   <= dout_next;
            err_reg    <= err_next;
            gnt_reg    <= gnt_next;
            dv_reg     <= dv_next;
            busy_reg   <= busy_next;
            strobe_reg <= strobe_next;
        end
    end

    assign gnt         = gnt_reg;
    assign dout        = dout_reg;
    assign dout_valid  = dv_reg;
    assign timeout_err = err_reg;
    assign busy        = busy_reg;
    assign rng_next    = strobe_reg;

`ifdef RGS_ARB_STATS_EN
    logic [15:0] gnt_count_reg;

    // Counts on the same edge that raises dout_valid, so the count already
    // includes the grant being delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_count_reg <= '0;
        end else if (dv_next && (gnt_count_reg != 16'hFFFF)) begin
            gnt_count_reg <= gnt_count_reg + 16'd1;
        end
    end

    assign gnt_count = gnt_count_reg;
`else
    assign gnt_count = '0;
`endif

endmodule

// File: tb/tb_rgs_rng_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rgs_rng_arbiter
//
// Directed test of rgs_rng_arbiter with default parameters (NREQ=4, DW=8,
// TIMEOUT=15). A table of single transactions is applied in a loop; reset,
// mid-transaction reset and round-robin fairness are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_rgs_rng_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic [DW-1:0]   dout;
    logic            dout_valid;
    logic            timeout_err;
    logic            busy;
    logic            rng_next;
    logic [DW-1:0]   rng_data = '0;
    logic            rng_valid = 1'b0;
    logic [15:0]     gnt_count;

    int n_vec = 0;
    int n_bad = 0;

    rgs_rng_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .timeout_err (timeout_err),
        .busy        (busy),
        .rng_next    (rng_next),
        .rng_data    (rng_data),
        .rng_valid   (rng_valid),
        .gnt_count   (gnt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] req;
        bit              hold;      // keep req until granted
        int              delay;     // cycles after rng_next until rng_valid, -1 = never
        logic [DW-1:0]   data;
        logic [NREQ-1:0] exp_gnt;
        logic [DW-1:0]   exp_dout;
        bit              exp_err;
        int              exp_lat;   // grant cycle, counting the req sample cycle as 0
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle (cycle 0) and returns in an IDLE cycle.
    task automatic run_txn(input vec_t v, input int id);
        int nstrobe;
        bit got;
        nstrobe   = 0;
        got       = 1'b0;
        req       = v.req;
        rng_valid = 1'b0;
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            step();
            if (!v.hold) req = '0;
            if (rng_next) nstrobe++;
            if (cyc == 1) check($sformatf("v%0d_rng_next_c1", id), rng_next, 1);
            if (gnt != '0) begin
                got = 1'b1;
                check($sformatf("v%0d_gnt", id), gnt, v.exp_gnt);
                check($sformatf("v%0d_dout", id), dout, v.exp_dout);
                check($sformatf("v%0d_dout_valid", id), dout_valid, 1);
                check($sformatf("v%0d_timeout_err", id), timeout_err, v.exp_err);
                check($sformatf("v%0d_latency", id), cyc, v.exp_lat);
                check($sformatf("v%0d_rng_next_count", id), nstrobe, 1);
                check($sformatf("v%0d_busy_deliver", id), busy, 1);
                req       = '0;
                rng_valid = 1'b0;
            end else begin
                check($sformatf("v%0d_busy_fetch_c%0d", id, cyc), busy, 1);
                check($sformatf("v%0d_dv_idle_c%0d", id, cyc), dout_valid, 0);
                rng_valid = (v.delay >= 0) && (cyc == 1 + v.delay);
                rng_data  = rng_valid ? v.data : ~v.data;
            end
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL v%0d_no_grant: got no gnt within 40 cycles, expected gnt 0x%0h", id, v.exp_gnt);
        end
        // Two quiet cycles: back in IDLE and no follow-on transaction.
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("v%0d_busy_after%0d", id, k), busy, 0);
            check($sformatf("v%0d_gnt_after%0d", id, k), gnt, 0);
            check($sformatf("v%0d_rng_next_after%0d", id, k), rng_next, 0);
        end
        $display("vector %0d: req=%b gnt=%b lat=%0d done", id, v.req, v.exp_gnt, v.exp_lat);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_dout_valid"}, dout_valid, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rng_next"}, rng_next, 0);
        check({tag, "_gnt_count"}, gnt_count, 0);
    endtask

    initial begin
        int exp_stats;
        int ng;
        int last_cyc;
        int gnt_seen;
        bit pending;

        // req, hold, delay, data, exp_gnt, exp_dout, exp_err, exp_lat
        vecs[0] = '{4'b0001, 1'b1,  0, 8'hA5, 4'b0001, 8'hA5, 1'b0,  2};  // first grant after reset
        vecs[1] = '{4'b0010, 1'b0,  3, 8'h3C, 4'b0010, 8'h3C, 1'b0,  5};  // request withdrawn
        vecs[2] = '{4'b0100, 1'b1, -1, 8'h99, 4'b0100, 8'h00, 1'b1, 17};  // core stall -> timeout
        vecs[3] = '{4'b0100, 1'b1, 15, 8'h5A, 4'b0100, 8'h5A, 1'b0, 17};  // data at expiry wins
        vecs[4] = '{4'b1000, 1'b1, 14, 8'h77, 4'b1000, 8'h77, 1'b0, 16};  // one cycle before expiry
        vecs[5] = '{4'b1001, 1'b1,  1, 8'h11, 4'b0001, 8'h11, 1'b0,  3};  // last=3 -> 0 wins
        vecs[6] = '{4'b1001, 1'b1,  0, 8'h22, 4'b1000, 8'h22, 1'b0,  2};  // last=0 -> 3 wins
        vecs[7] = '{4'b0110, 1'b1,  0, 8'h33, 4'b0010, 8'h33, 1'b0,  2};  // last=3 -> 1 wins
        vecs[8] = '{4'b0110, 1'b1,  0, 8'h44, 4'b0100, 8'h44, 1'b0,  2};  // last=1 -> 2 wins
        vecs[9] = '{4'b0011, 1'b1,  0, 8'h55, 4'b0001, 8'h55, 1'b0,  2};  // last=2 -> wraps to 0

`ifdef RGS_ARB_STATS_EN
        exp_stats = 1;
`else
        exp_stats = 0;
`endif

        // Reset for two cycles.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_all_zero("reset");
        $display("reset: outputs checked");

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i], i);
        end

        // Reset during FETCH (last is 0 here, so without a reset of last
        // requester 3 would win the follow-up).
        req       = 4'b0001;
        rng_valid = 1'b0;
        step();
        step();
        step();
        check("midrst_busy_before", busy, 1);
        rst = 1'b1;
        req = '0;
        step();
        check_all_zero("midrst");
        rst = 1'b0;
        gnt_seen = 0;
        for (int k = 0; k < TIMEOUT + 8; k++) begin
            step();
            if (gnt != '0) gnt_seen++;
        end
        check("midrst_no_gnt", gnt_seen, 0);
        check("midrst_idle", busy, 0);
        $display("midrst: dropped transaction, %0d stray grants", gnt_seen);
        run_txn('{4'b1001, 1'b1, 0, 8'h66, 4'b0001, 8'h66, 1'b0, 2}, 10);

        // Fairness: all four held, core always ready.
        rst = 1'b1;
        step();
        step();
        rst       = 1'b0;
        req       = 4'b1111;
        rng_valid = 1'b1;
        rng_data  = 8'hC3;
        ng        = 0;
        last_cyc  = 0;
        pending   = 1'b0;
        for (int c = 1; c <= 60 && ng < 12; c++) begin
            step();
            if (gnt != '0) begin
                check($sformatf("fair%0d_gnt", ng), gnt, 1 << (ng % 4));
                check($sformatf("fair%0d_dout", ng), dout, 8'hC3);
                check($sformatf("fair%0d_gap", ng), c - last_cyc, (ng == 0) ? 2 : 3);
                $display("fair grant %0d: gnt=%b cycle=%0d", ng, gnt, c);
                last_cyc = c;
                ng++;
                pending = 1'b1;
                if (ng == 12) req = '0;
            end else if (pending) begin
                check($sformatf("fair%0d_gnt_count", ng), gnt_count, exp_stats * ng);
                pending = 1'b0;
            end
        end
        check("fair_total", ng, 12);
        step();
        check("fair_final_gnt_count", gnt_count, exp_stats * 12);
        rng_valid = 1'b0;
        step();
        check("fair_final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rgs_rng_arbiter.md
# rgs_rng_arbiter

Round-robin arbiter and sequencer that shares the single randomizer core among several requesters. It serializes requests, issues one advance strobe to the core per grant, captures the core's output word and returns it to the winning requester with a one-cycle grant pulse. A fetch timeout keeps the block from deadlocking on a stalled core. It sits between the requesting logic inside `tt_rgs_randomizer` and the random-number datapath.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `DW`, default 8: random word width.
- `TIMEOUT`, default 15: maximum FETCH cycles to wait for `rng_valid`, 1..255.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in NREQ: level requests; each requester holds its bit until it sees its `gnt` bit.
- `gnt` out NREQ: one-hot grant, high for exactly one cycle, coincident with `dout_valid`.
- `dout` out DW: random word delivered to the granted requester; valid only while `dout_valid` is high.
- `dout_valid` out 1: delivery strobe.
- `timeout_err` out 1: high with `dout_valid` when the delivery came from a timeout; `dout` is 0 in that case.
- `busy` out 1: high in every state other than IDLE.
- `rng_next` out 1: advance strobe to the core, one cycle per transaction.
- `rng_data` in DW: core output word.
- `rng_valid` in 1: `rng_data` is valid this cycle.
- `gnt_count` out 16: grant statistics (see Configuration).

## Operation
- Three states:
  - IDLE: if any `req` bit is set, choose the winner by round-robin, searching upward from `last+1` modulo NREQ. Register the index, clear the timeout counter and go to FETCH.
  - FETCH: `rng_next`=1 on the first FETCH cycle only.
    - When `rng_valid`=1, capture `rng_data` and go to DELIVER with the error flag cleared.
    - Otherwise, when the counter reaches TIMEOUT, capture 0 and go to DELIVER with the error flag set.
    - Otherwise, increment the counter.
  - DELIVER: drive `gnt[idx]`, `dout_valid` and `timeout_err` per the captured flag; set `last`=idx; go to IDLE.
- `rng_valid` and counter expiry in the same cycle: data wins and `timeout_err`=0.
- `rng_valid` while in IDLE or DELIVER is ignored.
- A requester that drops `req` after selection still receives its `gnt` pulse. The transaction always completes.
- A requester that keeps `req` high after its grant is treated as a new request. Round-robin guarantees every other active requester is served before it is served again.
- All outputs are registered.
- Reset, including mid-transaction: state=IDLE, `last`=NREQ-1 (requester 0 has first priority), counter=0. The outputs `gnt`, `dout`, `dout_valid`, `timeout_err`, `busy`, `rng_next` and `gnt_count` all reset to 0. An in-flight transaction is dropped with no grant.

## Timing
- Cycle 0: IDLE samples `req`.
- Cycle 1: FETCH, `rng_next`=1.
- If `rng_valid`=1 in cycle 1, then cycle 2 is DELIVER (`gnt`/`dout_valid`=1) and cycle 3 is IDLE.
- Minimum request-to-grant latency: 2 cycles.
- Back-to-back grants are at least 3 cycles apart.
- Timeout path: with `rng_valid` never asserted, DELIVER occurs at cycle TIMEOUT+2.
- `busy`=1 from cycle 1 through the DELIVER cycle.

## Configuration
- `RGS_ARB_STATS_EN` defined: `gnt_count` increments on every DELIVER cycle, including timeout deliveries. It saturates at 16'hFFFF and is cleared by `rst`.
- `RGS_ARB_STATS_EN` undefined: `gnt_count` is tied to 0 and no counter is synthesized. All other behaviour is identical.

## Test plan
- Reset and first grant:
  - Stimulus: `rst` for 2 cycles, then `req`=4'b0001, with the core model returning `rng_valid`=1 and `rng_data`=8'hA5 in the `rng_next` cycle.
  - Required: `gnt`=4'b0001 and `dout`=8'hA5 exactly 2 cycles after `req` is first sampled; `rng_next` is high for 1 cycle only.
- Round-robin fairness:
  - Stimulus: `req`=4'b1111 held for 12 grants.
  - Required: grant order 0,1,2,3,0,1,2,3,…; each requester receives 3 grants, each 3 cycles apart.
- Core stall and timeout:
  - Stimulus: `req`=4'b0100, `rng_valid` held at 0.
  - Required: `gnt`=4'b0100, `dout`=0 and `timeout_err`=1 in cycle TIMEOUT+2 (17 with defaults).
  - Repeat with `rng_valid`=1 exactly at the expiry cycle: `timeout_err` must be 0.
- Request withdrawn:
  - Stimulus: `req`=4'b0010 for one cycle only, core delay of 3 cycles.
  - Required: `gnt`=4'b0010 is still pulsed; no second transaction follows.
- Reset mid-transaction:
  - Stimulus: assert `rst` during FETCH.
  - Required: all outputs 0 on the next cycle and no `gnt` is issued.
  - After release with `req`=4'b1000 and `req`=4'b0001 simultaneously: requester 0 wins first.
- Statistics:
  - With `RGS_ARB_STATS_EN`: `gnt_count`=5 after 5 grants.
  - Without it: `gnt_count` stays 0.
